window_loader: RTL and testbench

WINDOW_LOADER -- requirements
Module: window_loader

---
 rtl/npu_pkg.sv | 21 ++
 rtl/fmap_ram.sv | 28 ++
 rtl/window_loader.sv | 172 +++++++++++++++++
 tb/tb_window_loader.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: window-loader FSM states and the stride encoding.
// Stride code 0 is not a legal step and decodes to 1.
package npu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] STRIDE_0 = 2'd0;
    localparam logic [1:0] STRIDE_1 = 2'd1;
    localparam logic [1:0] STRIDE_2 = 2'd2;
    localparam logic [1:0] STRIDE_3 = 2'd3;

    function automatic logic [1:0] decode_stride(input logic [1:0] code);
        return (code == STRIDE_0) ? STRIDE_1 : code;
    endfunction

endpackage

// File: rtl/fmap_ram.sv
// Feature-map buffer: one synchronous write port, one synchronous read port.
// Read latency 1 cycle; no backpressure. Contents are deliberately not reset.
module fmap_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/window_loader.sv
// Sweeps a KxK window over the feature map at a programmable stride.
// Latency: window valid K*K+1 cycles after each FETCH entry; holds while win_ready is low.
module window_loader
    import npu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  start,
    input  logic [1:0]            stride,
    output logic                  busy,
    output logic                  done,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [K*K*DATA_W-1:0] win_data,
    output logic [ADDR_W-1:0]     win_row,
    output logic [ADDR_W-1:0]     win_col
);

    localparam int KK  = K * K;
    localparam int CW  = $clog2(KK + 1);
    localparam int AW1 = ADDR_W + 1;
    localparam int WW  = KK * DATA_W;

    typedef logic [AW1-1:0] coord_t;

    localparam logic [CW-1:0] KK_C  = CW'(KK);
    localparam logic [CW-1:0] KM1_C = CW'(K - 1);
    localparam coord_t        K_X   = coord_t'(K);
    localparam coord_t        IW_X  = coord_t'(IMG_W);
    localparam coord_t        IH_X  = coord_t'(IMG_H);

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, rr, cc;
    logic              rd_en, rd_pend;
    logic [1:0]        stride_q;
    coord_t            row_q, col_q;
    coord_t            s_x, pix_y, pix_x, rd_addr_x;
    logic              col_fits, row_fits;
    logic [DATA_W-1:0] ram_q;
    logic [WW-1:0]     win_q;

    fmap_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W * IMG_H),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en && (state == IDLE)),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr_x[ADDR_W-1:0]),
        .rd_data (ram_q)
    );

    // One spare coordinate bit keeps the edge tests from wrapping.
    always_comb begin
        s_x       = coord_t'(stride_q);
        pix_y     = row_q + coord_t'(rr);
        pix_x     = col_q + coord_t'(cc);
        rd_addr_x = pix_y * IW_X + pix_x;
        col_fits  = (col_q + s_x + K_X) <= IW_X;
        row_fits  = (row_q + s_x + K_X) <= IH_X;
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                rd_en = (cnt < KK_C);
                if (cnt == KK_C) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (win_ready) begin
                    state_nxt = (col_fits || row_fits) ? FETCH : DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rr       <= '0;
            cc       <= '0;
            rd_pend  <= 1'b0;
            stride_q <= STRIDE_1;
            row_q    <= '0;
            col_q    <= '0;
            win_q    <= '0;
        end else begin
            state   <= state_nxt;
            rd_pend <= rd_en;
            // Element (0,0) is read first, so after K*K shifts it lands in slot 0.
            if (rd_pend) begin
                win_q <= {ram_q, win_q[WW-1:DATA_W]};
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        stride_q <= decode_stride(stride);
                        row_q    <= '0;
                        col_q    <= '0;
                        cnt      <= '0;
                        rr       <= '0;
                        cc       <= '0;
                    end
                end
                FETCH: begin
                    if (rd_en) begin
                        cnt <= cnt + 1'b1;
                        if (cc == KM1_C) begin
                            cc <= '0;
                            rr <= rr + 1'b1;
                        end else begin
                            cc <= cc + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (win_ready) begin
                        cnt <= '0;
                        rr  <= '0;
                        cc  <= '0;
                        if (col_fits) begin
                            col_q <= col_q + s_x;
                        end else begin
                            col_q <= '0;
                            if (row_fits) begin
                                row_q <= row_q + s_x;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state == FETCH) || (state == HOLD);
    assign done      = (state == DONE);
    assign win_valid = (state == HOLD);
    assign win_data  = win_q;
    assign win_row   = row_q[ADDR_W-1:0];
    assign win_col   = col_q[ADDR_W-1:0];

endmodule

// File: tb/tb_window_loader.sv
// Directed bench for window_loader on an 8x8 map, K=3, preloaded with ram[a] = a+1.
module tb_window_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        start = 1'b0;
    logic [1:0]  stride = 2'd1;
    logic        busy, done, win_valid;
    logic        win_ready = 1'b1;
    logic [71:0] win_data;
    logic [5:0]  win_row, win_col;

    int checks = 0;
    int errors = 0;

    window_loader dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .stride    (stride),
        .busy      (busy),
        .done      (done),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .win_row   (win_row),
        .win_col   (win_col)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input int r0, input int c0);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[8*(r*3+c) +: 8] = 8'((r0 + r) * 8 + c0 + c + 1);
        return w;
    endfunction

    // Runs one sweep; optionally stalls one window, aborts with reset, or pokes a write while busy.
    task automatic run_sweep(input logic [1:0] s, input int stall_win, input int abort_win,
                             input bit poke, output int n, output logic [71:0] first_dat,
                             output logic [71:0] last_dat, output int last_r, output int last_c);
        int eff, er, ec, cyc, done_cnt;
        bit finished, aborted;
        logic [71:0] held;
        eff = (s == 2'd0) ? 1 : int'(s);
        er = 0; ec = 0; n = 0; cyc = 0; done_cnt = 0;
        finished = 0; aborted = 0;
        first_dat = '0; last_dat = '0; last_r = -1; last_c = -1;
        @(negedge clk); start = 1'b1; stride = s;
        @(negedge clk); start = 1'b0;
        chk("busy_on", 72'(busy), 72'(1));
        while (!finished && cyc < 3000) begin
            if (poke && cyc == 0) begin
                wr_en = 1'b1; wr_addr = 6'd0; wr_data = 8'd99;
            end else begin
                wr_en = 1'b0;
            end
            if (done) begin
                done_cnt++;
                finished = 1;
            end else if (win_valid) begin
                if (n == 0) begin
                    chk("first_latency", 72'(cyc), 72'(10));
                    first_dat = win_data;
                end
                chk("win_data", win_data, exp_win(er, ec));
                chk("win_row", 72'(win_row), 72'(er));
                chk("win_col", 72'(win_col), 72'(ec));
                last_dat = win_data; last_r = int'(win_row); last_c = int'(win_col);
                if (n == stall_win) begin
                    win_ready = 1'b0;
                    held = win_data;
                    repeat (10) begin
                        @(negedge clk); cyc++;
                        chk("stall_valid", 72'(win_valid), 72'(1));
                        chk("stall_data", win_data, held);
                        chk("stall_col", 72'(win_col), 72'(1));
                    end
                    win_ready = 1'b1;
                end
                if (n == abort_win) begin
                    rst = 1'b0;
                    @(negedge clk);
                    chk("abort_busy", 72'(busy), 72'(0));
                    chk("abort_valid", 72'(win_valid), 72'(0));
                    chk("abort_done", 72'(done), 72'(0));
                    rst = 1'b1;
                    repeat (12) begin
                        @(negedge clk);
                        if (done) chk("abort_no_done", 72'(done), 72'(0));
                    end
                    chk("abort_idle", 72'(busy), 72'(0));
                    aborted = 1;
                    finished = 1;
                end
                if (ec + eff + 3 <= 8) begin
                    ec += eff;
                end else begin
                    ec = 0;
                    er += eff;
                end
                n++;
            end
            if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end
        wr_en = 1'b0;
        if (!aborted) begin
            if (!finished) chk("sweep_timeout", 72'(0), 72'(1));
            chk("done_pulses", 72'(done_cnt), 72'(1));
            @(negedge clk);
            chk("done_one_cycle", 72'(done), 72'(0));
            chk("busy_off", 72'(busy), 72'(0));
        end
    endtask

    int n;
    logic [71:0] fd, ld;
    int lr, lc;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 72'(busy), 72'(0));
        chk("rst_done", 72'(done), 72'(0));
        chk("rst_valid", 72'(win_valid), 72'(0));
        chk("rst_data", win_data, 72'(0));
        chk("rst_row", 72'(win_row), 72'(0));
        chk("rst_col", 72'(win_col), 72'(0));
        rst = 1'b1;

        for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 6'(a); wr_data = 8'(a + 1);
        end
        @(negedge clk); wr_en = 1'b0;

        // stride 1, with a 10-cycle stall on the second window
        run_sweep(2'd1, 1, -1, 1'b0, n, fd, ld, lr, lc);
        chk("s1_count", 72'(n), 72'(36));
        chk("s1_first", fd, {8'd19, 8'd18, 8'd17, 8'd11, 8'd10, 8'd9, 8'd3, 8'd2, 8'd1});
        chk("s1_last", ld, {8'd64, 8'd63, 8'd62, 8'd56, 8'd55, 8'd54, 8'd48, 8'd47, 8'd46});
        chk("s1_last_row", 72'(lr), 72'(5));
        chk("s1_last_col", 72'(lc), 72'(5));

        run_sweep(2'd2, -1, -1, 1'b0, n, fd, ld, lr, lc);
        chk("s2_count", 72'(n), 72'(9));
        chk("s2_last_tl", 72'(ld[7:0]), 72'(37));
        chk("s2_last_row", 72'(lr), 72'(4));
        chk("s2_last_col", 72'(lc), 72'(4));

        // stride 3 with a write attempted while busy
        run_sweep(2'd3, -1, -1, 1'b1, n, fd, ld, lr, lc);
        chk("s3_count", 72'(n), 72'(4));
        chk("s3_last_row", 72'(lr), 72'(3));
        chk("s3_last_col", 72'(lc), 72'(3));

        run_sweep(2'd0, -1, -1, 1'b0, n, fd, ld, lr, lc);
        chk("s0_count", 72'(n), 72'(36));
        chk("s0_first_elem", 72'(fd[7:0]), 72'(1));

        // abort on the fifth window, then replay from (0,0)
        run_sweep(2'd1, -1, 4, 1'b0, n, fd, ld, lr, lc);
        chk("abort_count", 72'(n), 72'(5));
        run_sweep(2'd1, -1, -1, 1'b0, n, fd, ld, lr, lc);
        chk("replay_count", 72'(n), 72'(36));
        chk("replay_first", fd, {8'd19, 8'd18, 8'd17, 8'd11, 8'd10, 8'd9, 8'd3, 8'd2, 8'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
